decode_stage: RTL
=================

Name: decode_stage

Overview:
- Fetch-to-decode pipeline register of the RISC-V core, directly upstream of the immediate generator.
- Accepts fetched instructions over a valid/ready handshake and buffers them with a one-entry skid buffer.
- Pre-decodes the opcode into imm_sel, has_imm and illegal flags, registered alongside the instruction.
- Supplies imm_gen with a registered instruction and matching imm_sel in the same cycle.

Parameters:
- RESET_PC, 32'h0000_0000, value of id_pc after reset and flush
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) presented when id_valid=0

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- if_inst  input  32  fetched instruction
- if_pc  input  32  PC of if_inst
- if_valid  input  1  fetch offers if_inst/if_pc
- if_ready  output  1  stage accepts this cycle
- flush  input  1  kill all held instructions (branch/jump redirect)
- id_inst  output  32  registered instruction to imm_gen / control
- id_pc  output  32  registered PC
- id_valid  output  1  id_* outputs hold a live instruction
- id_ready  input  1  downstream consumes id_* this cycle
- imm_sel  output  3  I=000, S=001, B=010, U=011, J=100
- has_imm  output  1  instruction uses an immediate
- illegal  output  1  unrecognised opcode (only meaningful when id_valid=1)

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle including mid-transfer):
  - id_valid=0, skid_valid=0, id_inst=NOP_INST, id_pc=RESET_PC, imm_sel=000, has_imm=1, illegal=0.
  - if_ready=1 from the first cycle after release.
- Opcode decode is applied on the input path to inst[6:0]; decoded fields are stored with the instruction in both the output and skid registers.
  - 0010011, 0000011, 1100111, 1110011 -> I (000), has_imm=1.
  - 0100011 -> S (001), has_imm=1.
  - 1100011 -> B (010), has_imm=1.
  - 0110111, 0010111 -> U (011), has_imm=1.
  - 1101111 -> J (100), has_imm=1.
  - 0110011 -> imm_sel=000, has_imm=0.
  - Any other opcode -> imm_sel=000, has_imm=0, illegal=1.
- Handshake:
  - accept = if_valid & if_ready.
  - consume = id_valid & id_ready.
  - if_ready = !skid_valid, registered-derived; no combinational path from id_ready.
- Latency: one cycle from accept to id_valid=1 when the output register is empty or being consumed.
- Register update (no flush):
  - Output free (!id_valid or consume), skid_valid=1 -> skid moves to output; a same-cycle accept goes into the skid.
  - Output free, skid empty -> an accept loads the output directly; with no accept, id_valid=0.
  - Output held (id_valid & !id_ready) with accept -> entry goes to the skid, skid_valid=1, if_ready drops next cycle.
  - Output held, no accept -> all registers hold.
- Ordering: strict FIFO. The skid entry always precedes any newly accepted entry.
- Flush (highest priority after reset):
  - Next cycle: id_valid=0, skid_valid=0, id_inst=NOP_INST, id_pc=RESET_PC, decode fields = NOP decode.
  - A same-cycle accept is dropped; if_ready is unaffected by flush.
  - A same-cycle consume still counts as consumed by downstream.
- While id_valid=0, outputs hold NOP_INST values, so imm_gen sees a harmless I-type word.
- The outputs never change while id_valid=1 and id_ready=0.

Decomposition:
- Shared package (riscv_pkg), used by imm_gen, the decode stage and control:
  - Opcode localparams: OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP.
  - IMM_I/S/B/U/J selector constants.
  - NOP encoding.
- One combinational sub-module, imm_sel_decode (inst[6:0] -> imm_sel, has_imm, illegal), instantiated once on the input path.

Test Plan:
- Reset, then in successive cycles with id_ready=1:
  - offer 0x00300113 -> imm_sel=000;
  - 0x00628263 -> 010;
  - 0x001120A3 -> 001;
  - 0x00001137 -> 011;
  - 0x004000EF -> 100.
  - Each appears on id_inst exactly one cycle after acceptance.
  - 0x002081B3 -> has_imm=0.
  - 0x0000007F -> illegal=1.
- Backpressure:
  - Hold id_ready=0 with A=0x00300113 in the output; offer B=0x00628263 -> B goes to the skid and if_ready=0 next cycle.
  - Release id_ready -> A consumed, then B; no loss, no duplication, if_ready=1 again.
- Flush with both registers full -> next cycle id_valid=0, id_inst=0x00000013, if_ready=1, and the instruction offered in the flush cycle never appears.
- Simultaneous consume and accept with the skid empty -> the output is replaced in one cycle; skid_valid stays 0 across 10 back-to-back instructions (full throughput).
- rst_n asserted asynchronously mid-cycle while the skid is full -> all outputs go to reset values immediately; the first post-reset accept appears one cycle later.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by imm_gen, the decode stage and control:
// major opcodes, immediate-format selectors, the canonical NOP and the
// record that travels through the fetch-to-decode register.
package riscv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  // One buffered instruction together with its pre-decoded fields.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  imm_sel;
    logic        has_imm;
    logic        illegal;
  } id_entry_t;

endpackage

// File: rtl/imm_sel_decode.sv
// Opcode pre-decoder: maps inst[6:0] to the immediate format, whether an
// immediate is used at all, and whether the opcode is recognised.
module imm_sel_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output logic       has_imm,
  output logic       illegal
);

  // Unknown opcodes fall back to an I-format selector so imm_gen stays benign.
  always_comb begin
    imm_sel = IMM_I;
    has_imm = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        imm_sel = IMM_I;
        has_imm = 1'b1;
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
        has_imm = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel = IMM_B;
        has_imm = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_sel = IMM_U;
        has_imm = 1'b1;
      end
      OPC_JAL: begin
        imm_sel = IMM_J;
        has_imm = 1'b1;
      end
      OPC_OP: begin
        imm_sel = IMM_I;
        has_imm = 1'b0;
      end
      default: begin
        imm_sel = IMM_I;
        has_imm = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer. The opcode
// is pre-decoded on the input path so imm_gen receives the instruction and its
// imm_sel from the same register. if_ready depends only on the skid state, so
// there is no combinational path from id_ready back to fetch.
module decode_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic        flush,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [2:0]  imm_sel,
  output logic        has_imm,
  output logic        illegal
);

  // Bubble contents: the NOP word decodes as I-type with an immediate.
  localparam id_entry_t BUBBLE = '{
    inst:    NOP_INST,
    pc:      RESET_PC,
    imm_sel: IMM_I,
    has_imm: 1'b1,
    illegal: 1'b0
  };

  id_entry_t   out_q;
  id_entry_t   skid_q;
  id_entry_t   in_entry;
  logic        out_valid;
  logic        skid_valid;
  logic [2:0]  in_imm_sel;
  logic        in_has_imm;
  logic        in_illegal;
  logic        accept;
  logic        out_free;

  imm_sel_decode u_imm_sel_decode (
    .opcode  (if_inst[6:0]),
    .imm_sel (in_imm_sel),
    .has_imm (in_has_imm),
    .illegal (in_illegal)
  );

  assign in_entry = '{
    inst:    if_inst,
    pc:      if_pc,
    imm_sel: in_imm_sel,
    has_imm: in_has_imm,
    illegal: in_illegal
  };

  assign if_ready = !skid_valid;
  assign accept   = if_valid && if_ready;
  assign out_free = !out_valid || id_ready;

  // Output and skid registers: the skid always drains before new input, and
  // an emptied output register falls back to the bubble contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= BUBBLE;
      out_valid  <= 1'b0;
      skid_q     <= BUBBLE;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_q      <= BUBBLE;
      out_valid  <= 1'b0;
      skid_q     <= BUBBLE;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= accept;
        if (accept) begin
          skid_q <= in_entry;
        end
      end else if (accept) begin
        out_q     <= in_entry;
        out_valid <= 1'b1;
      end else begin
        out_q     <= BUBBLE;
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end
  end

  assign id_inst  = out_q.inst;
  assign id_pc    = out_q.pc;
  assign id_valid = out_valid;
  assign imm_sel  = out_q.imm_sel;
  assign has_imm  = out_q.has_imm;
  assign illegal  = out_q.illegal;

endmodule
